call_stack_ctrl: RTL and testbench
==================================

Name: call_stack_ctrl

Overview:
Return-address stack controller for the CPU sequencer, replacing the single-entry call register with a 2^REG_BIT_CNT-deep LIFO. A call pushes the supplied counter value and a return pops it. The block exposes the current top of stack as the return address, tracks depth, and flags overflow and underflow. It sits between the instruction decoder (cal_f/ret_f) and the program counter mux (ret_addr).

Parameters:
CNTR_WIDTH, 8, width of program counter / stored return address
REG_BIT_CNT, 3, log2 of stack depth (depth = 1<<REG_BIT_CNT)

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
cal_f  input  1  call strobe, push counter this cycle
ret_f  input  1  return strobe, pop top this cycle
err_clr  input  1  clears sticky error flags
counter  input  CNTR_WIDTH  return address to push
ret_addr  output  CNTR_WIDTH  current top-of-stack value
depth  output  REG_BIT_CNT+1  number of valid entries, 0..1<<REG_BIT_CNT
empty  output  1  depth == 0
full  output  1  depth == 1<<REG_BIT_CNT
ovf_err  output  1  sticky: push attempted while full
unf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset: synchronous only. On posedge clk with rst_n=0: depth=0, all entries=0, ovf_err=0, unf_err=0. Outputs after reset: ret_addr=0, empty=1, full=0. Reset overrides every other input.
- ret_addr: combinational read of entry[depth-1]. Forced to 0 when empty. Changes the cycle after a push or pop (1-cycle latency from strobe to new top).
- empty and full: combinational decodes of depth.
- Operation per posedge, rst_n=1, decoded on {cal_f, ret_f}:
  - 00: hold.
  - 10, not full: entry[depth] <= counter; depth +1.
  - 10, full: no write, depth held, ovf_err <= 1.
  - 01, not empty: depth -1. Entry contents are not cleared.
  - 01, empty: depth held (stays 0), unf_err <= 1.
  - 11, not empty (including full): replace top, entry[depth-1] <= counter; depth unchanged; no error.
  - 11, empty: treated as push; entry[0] <= counter; depth=1; unf_err <= 1.
- Error flags are sticky and cleared only by err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- Depth counter arithmetic is unsigned REG_BIT_CNT+1 bits and never wraps. Saturation is guaranteed by the full/empty guards.
- Write index is depth[REG_BIT_CNT-1:0] for a push and depth-1 for a replace.
- No X propagation: unwritten entries read 0 because of reset.

Decomposition:
- Package call_stack_pkg holds STACK_DEPTH = 1<<REG_BIT_CNT and the localparam op encodings OP_NOP, OP_PUSH, OP_POP, OP_REPL.
- Sub-module call_stack_mem: a 2^REG_BIT_CNT x CNTR_WIDTH register file with one synchronous write port, one combinational read port, and synchronous reset to 0.
- call_stack_ctrl contains the op decode, depth counter, flag logic and ret_addr masking.

Test Plan:
1. Reset then idle: rst_n=0 for 2 clk, release -> depth=0, empty=1, full=0, ret_addr=0, both errors 0.
2. Nested calls: push 0x10, 0x20, 0x30, then three pops -> ret_addr sequence 0x30, 0x20, 0x10, then 0. Depth goes 3, 2, 1, 0 and empty reasserts.
3. Overflow at depth 8: push 0x01..0x08 (full=1), then push 0xFF -> depth stays 8, ret_addr=0x08, ovf_err=1. Pulse err_clr -> ovf_err=0.
4. Underflow: pop while empty -> depth=0, unf_err=1. Repeat the pop with err_clr high the same cycle -> unf_err remains 1.
5. Simultaneous call+return: at depth 2 (top 0x20), cal_f=ret_f=1 with counter=0x55 -> depth=2, ret_addr=0x55. When empty, the same stimulus -> depth=1, ret_addr=0x55, unf_err=1.
6. Mid-operation reset: at depth 5, assert rst_n=0 together with cal_f=1 -> next cycle depth=0, ret_addr=0, no push recorded. A subsequent pop sets unf_err.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared constants for the return-address stack controller.
package call_stack_pkg;

  // Default stack sizing; modules derive their own depth from REG_BIT_CNT.
  localparam int unsigned REG_BIT_CNT_DEF = 3;
  localparam int unsigned STACK_DEPTH     = 1 << REG_BIT_CNT_DEF;

  // Operation encodings, indexed by {cal_f, ret_f}.
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Number of stack entries for a given index width.
  function automatic int unsigned stack_depth(input int unsigned reg_bit_cnt);
    return 1 << reg_bit_cnt;
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Stack storage: one synchronous write port, one combinational read port,
// synchronously cleared to zero so unwritten entries never read X.
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH  = 8,
  parameter int unsigned REG_BIT_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [REG_BIT_CNT-1:0] waddr,
  input  logic [CNTR_WIDTH-1:0]  wdata,
  input  logic [REG_BIT_CNT-1:0] raddr,
  output logic [CNTR_WIDTH-1:0]  rdata
);

  localparam int unsigned Depth = stack_depth(REG_BIT_CNT);

  logic [CNTR_WIDTH-1:0] mem_q [Depth];

  // Entry storage: reset clears every entry, otherwise write on we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address LIFO controller: decodes call/return strobes, tracks depth,
// raises sticky overflow/underflow flags and presents the top of stack.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH  = 8,
  parameter int unsigned REG_BIT_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cal_f,
  input  logic                   ret_f,
  input  logic                   err_clr,
  input  logic [CNTR_WIDTH-1:0]  counter,
  output logic [CNTR_WIDTH-1:0]  ret_addr,
  output logic [REG_BIT_CNT:0]   depth,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam int unsigned DW = REG_BIT_CNT + 1;
  localparam logic [DW-1:0] DepthOne  = DW'(1);
  localparam logic [DW-1:0] DepthFull = DW'(stack_depth(REG_BIT_CNT));

  logic [DW-1:0]          depth_q, depth_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [1:0]             op;
  logic [REG_BIT_CNT-1:0] top_idx;
  logic                   we;
  logic [REG_BIT_CNT-1:0] waddr;
  logic                   ovf_set, unf_set;
  logic [CNTR_WIDTH-1:0]  rdata;

  assign op    = {cal_f, ret_f};
  assign empty = (depth_q == '0);
  assign full  = (depth_q == DepthFull);
  // At full the low bits wrap to 0, so subtracting one lands on the last entry.
  assign top_idx = depth_q[REG_BIT_CNT-1:0] - REG_BIT_CNT'(1);

  // Op decode: next depth, write port control and error requests.
  always_comb begin
    depth_d = depth_q;
    we      = 1'b0;
    waddr   = depth_q[REG_BIT_CNT-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          depth_d = depth_q + DepthOne;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          depth_d = depth_q - DepthOne;
        end
      end
      OP_REPL: begin
        we = 1'b1;
        if (empty) begin
          // Nothing to replace: behave as a push but still report the bad pop.
          waddr   = '0;
          depth_d = DepthOne;
          unf_set = 1'b1;
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
    // A new error in the same cycle as err_clr wins.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  // Depth counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  call_stack_mem #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .REG_BIT_CNT(REG_BIT_CNT)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(counter),
    .raddr(top_idx),
    .rdata(rdata)
  );

  assign ret_addr = empty ? '0 : rdata;
  assign depth    = depth_q;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed self-checking bench for call_stack_ctrl.
module tb_call_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cal_f, ret_f, err_clr;
  logic [7:0] counter;
  logic [7:0] ret_addr;
  logic [3:0] depth;
  logic       empty, full, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  call_stack_ctrl #(
    .CNTR_WIDTH (8),
    .REG_BIT_CNT(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cal_f   (cal_f),
    .ret_f   (ret_f),
    .err_clr (err_clr),
    .counter (counter),
    .ret_addr(ret_addr),
    .depth   (depth),
    .empty   (empty),
    .full    (full),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  // Apply one cycle of stimulus, then sample 1ns after the edge.
  task automatic cycle(input logic c, input logic r, input logic e, input logic [7:0] v);
    cal_f   = c;
    ret_f   = r;
    err_clr = e;
    counter = v;
    @(posedge clk);
    #1;
    cal_f   = 1'b0;
    ret_f   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", depth); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (ret_addr !== 8'h00) begin errors++; $display("FAIL reset_ret got %h want 00", ret_addr); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL reset_unf got %b want 0", unf_err); end
  endtask

  task automatic test_nested();
    logic [7:0] vals [3] = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, vals[i]);
      checks++; if (depth !== 4'(i + 1)) begin errors++; $display("FAIL nest_push_depth got %0d want %0d", depth, i + 1); end
      checks++; if (ret_addr !== vals[i]) begin errors++; $display("FAIL nest_push_ret got %h want %h", ret_addr, vals[i]); end
    end
    for (int i = 2; i >= 0; i--) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (depth !== 4'(i)) begin errors++; $display("FAIL nest_pop_depth got %0d want %0d", depth, i); end
      checks++;
      if (ret_addr !== ((i == 0) ? 8'h00 : vals[i - 1])) begin
        errors++; $display("FAIL nest_pop_ret got %h at depth %0d", ret_addr, i);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nest_empty got %b want 1", empty); end
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL nest_unf got %b want 0", unf_err); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
    checks++; if (depth !== 4'd8) begin errors++; $display("FAIL ovf_depth8 got %0d want 8", depth); end
    cycle(1'b1, 1'b0, 1'b0, 8'hFF);
    checks++; if (depth !== 4'd8) begin errors++; $display("FAIL ovf_depth_hold got %0d want 8", depth); end
    checks++; if (ret_addr !== 8'h08) begin errors++; $display("FAIL ovf_ret got %h want 08", ret_addr); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_err); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf_err); end
    // Drain to check every stored entry, including index 0 and 7.
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (ret_addr !== 8'(i)) begin errors++; $display("FAIL ovf_drain got %h want %h", ret_addr, 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL unf_depth got %0d want 0", depth); end
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", unf_err); end
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL unf_new_wins got %b want 1", unf_err); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL unf_clr got %b want 0", unf_err); end
  endtask

  task automatic test_call_ret();
    cycle(1'b1, 1'b0, 1'b0, 8'h10);
    cycle(1'b1, 1'b0, 1'b0, 8'h20);
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    checks++; if (depth !== 4'd2) begin errors++; $display("FAIL repl_depth got %0d want 2", depth); end
    checks++; if (ret_addr !== 8'h55) begin errors++; $display("FAIL repl_ret got %h want 55", ret_addr); end
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL repl_unf got %b want 0", unf_err); end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (ret_addr !== 8'h10) begin errors++; $display("FAIL repl_below got %h want 10", ret_addr); end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    checks++; if (depth !== 4'd1) begin errors++; $display("FAIL repl_empty_depth got %0d want 1", depth); end
    checks++; if (ret_addr !== 8'h55) begin errors++; $display("FAIL repl_empty_ret got %h want 55", ret_addr); end
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL repl_empty_unf got %b want 1", unf_err); end
    // Replace while full: depth stays 8, top changes, no overflow.
    for (int i = 2; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 1'b0, 8'h77);
    checks++; if (depth !== 4'd8) begin errors++; $display("FAIL repl_full_depth got %0d want 8", depth); end
    checks++; if (ret_addr !== 8'h77) begin errors++; $display("FAIL repl_full_ret got %h want 77", ret_addr); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL repl_full_ovf got %b want 0", ovf_err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
    checks++; if (depth !== 4'd5) begin errors++; $display("FAIL mrst_pre_depth got %0d want 5", depth); end
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    rst_n = 1'b1;
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL mrst_depth got %0d want 0", depth); end
    checks++; if (ret_addr !== 8'h00) begin errors++; $display("FAIL mrst_ret got %h want 00", ret_addr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b want 1", empty); end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL mrst_unf got %b want 1", unf_err); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL mrst_pop_depth got %0d want 0", depth); end
  endtask

  initial begin
    rst_n   = 1'b0;
    cal_f   = 1'b0;
    ret_f   = 1'b0;
    err_clr = 1'b0;
    counter = 8'h00;
    test_reset();
    test_nested();
    test_overflow();
    test_underflow();
    test_call_ret();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
